// File: rtl/irq_gen_pkg.sv
// Shared definitions for the irq_gen interrupt transmitter: line count, FSM
// encodings and the width helper used to size the per-line holdoff counter.
package irq_gen_pkg;

    localparam int IRQ_NUM_LINES = 30;

    typedef enum logic {
        IRQ_ST_IDLE = 1'b0,
        IRQ_ST_HOLD = 1'b1
    } irq_state_e;

    // Bits needed to represent values 0..value-1 (at least 1).
    function automatic int irq_clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/irq_gen_line.sv
// One interrupt line: synchroniser, edge/level qualification, holdoff FSM,
// pending coalescing and (with IRQ_LOST_TRACK_EN defined) the sticky lost flag.
module irq_line
    import irq_gen_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 16,
    parameter bit LEVEL          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dev_irq,
    input  logic irq_mask,
    input  logic lost_clr,
    output logic ir_map,
    output logic pending,
    output logic lost
);

    localparam int              CNT_W    = irq_clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_prev_q, s_prev_d;
    irq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ir_map_q, ir_map_d;
    logic                   pending_q, pending_d;
    logic                   s;
    logic                   edge_det;
    logic                   req;
    logic                   lost_set;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], dev_irq};
        s        = sync_q[SYNC_STAGES-1];
        s_prev_d = s;
        edge_det = s & ~s_prev_q & irq_mask;
        // A pending edge is only honoured while the line is still enabled.
        req      = LEVEL ? (s & irq_mask) : (edge_det | (pending_q & irq_mask));

        state_d   = state_q;
        cnt_d     = cnt_q;
        ir_map_d  = 1'b0;
        pending_d = pending_q & irq_mask;
        lost_set  = 1'b0;

        case (state_q)
            IRQ_ST_IDLE: begin
                if (req) begin
                    ir_map_d  = 1'b1;
                    pending_d = 1'b0;
                    cnt_d     = CNT_LOAD;
                    state_d   = IRQ_ST_HOLD;
                end
            end
            IRQ_ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IRQ_ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // Edges during holdoff coalesce into a single deferred pulse.
                if (!LEVEL && edge_det) begin
                    pending_d = 1'b1;
                    lost_set  = pending_q;
                end
            end
            default: begin
                state_d = IRQ_ST_IDLE;
            end
        endcase

        if (LEVEL) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            s_prev_q  <= 1'b0;
            state_q   <= IRQ_ST_IDLE;
            cnt_q     <= '0;
            ir_map_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_prev_q  <= s_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ir_map_q  <= ir_map_d;
            pending_q <= pending_d;
        end
    end

    assign ir_map  = ir_map_q;
    assign pending = pending_q;

`ifdef IRQ_LOST_TRACK_EN
    logic lost_q, lost_d;

    // A new drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        lost_d = lost_set | (lost_q & ~lost_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_q <= 1'b0;
        end else begin
            lost_q <= lost_d;
        end
    end

    assign lost = lost_q;
`else
    logic unused_lost;
    assign unused_lost = lost_clr ^ lost_set;
    assign lost        = 1'b0;
`endif

endmodule

// File: rtl/irq_gen.sv
// Interrupt transmitter producing one-cycle, rate-limited pulses for CP0 ir_map[30:1].
// Define IRQ_LOST_TRACK_EN to keep the sticky per-line lost flags.
module irq_gen
    import irq_gen_pkg::*;
#(
    parameter int                 NUM_IRQ        = IRQ_NUM_LINES,
    parameter int                 SYNC_STAGES    = 2,
    parameter int                 HOLDOFF_CYCLES = 16,
    parameter logic [NUM_IRQ-1:0] LEVEL_MASK     = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] dev_irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic [NUM_IRQ-1:0] ir_map,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] lost,
    input  logic [NUM_IRQ-1:0] lost_clr
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("irq_gen: SYNC_STAGES must be >= 2");
    end
    if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
        $error("irq_gen: HOLDOFF_CYCLES must be >= 1");
    end

    // Bit gi of every vector is CP0 line gi+1.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
        irq_line #(
            .SYNC_STAGES    (SYNC_STAGES),
            .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
            .LEVEL          (LEVEL_MASK[gi])
        ) u_line (
            .clk      (clk),
            .rst_n    (rst_n),
            .dev_irq  (dev_irq[gi]),
            .irq_mask (irq_mask[gi]),
            .lost_clr (lost_clr[gi]),
            .ir_map   (ir_map[gi]),
            .pending  (pending[gi]),
            .lost     (lost[gi])
        );
    end

endmodule

// File: tb/tb_irq_gen.sv
// Directed self-checking bench for irq_gen (line 7 level, all others edge).
module tb_irq_gen;

    localparam int          N     = 30;
    localparam logic [N-1:0] LMASK = 30'h40;

`ifdef IRQ_LOST_TRACK_EN
    localparam logic EXP_LOST = 1'b1;
`else
    localparam logic EXP_LOST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] dev_irq;
    logic [N-1:0] irq_mask;
    logic [N-1:0] ir_map;
    logic [N-1:0] pending;
    logic [N-1:0] lost;
    logic [N-1:0] lost_clr;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt;

    always #5 clk = ~clk;

    irq_gen #(
        .NUM_IRQ        (N),
        .SYNC_STAGES    (2),
        .HOLDOFF_CYCLES (16),
        .LEVEL_MASK     (LMASK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dev_irq  (dev_irq),
        .irq_mask (irq_mask),
        .ir_map   (ir_map),
        .pending  (pending),
        .lost     (lost),
        .lost_clr (lost_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        dev_irq  = '0;
        irq_mask = '1;
        lost_clr = '0;
        step(3);
        check("rst_ir_map", 32'(ir_map), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_lost", 32'(lost), 32'h0);
        rst_n = 1'b1;
        step(2);

        // Line 5: latency of SYNC_STAGES edges, single-cycle pulse.
        for (int c = 0; c < 5; c++) begin
            dev_irq[4] = 1'b1;
            step(1);
            check($sformatf("l5_map_c%0d", c), 32'(ir_map), (c == 2) ? 32'h10 : 32'h0);
            check($sformatf("l5_pend_c%0d", c), 32'(pending[4]), 32'h0);
        end
        dev_irq[4] = 1'b0;
        step(20);

        // Line 3: three edges during holdoff coalesce into one pulse 17 cycles later.
        for (int c = 0; c < 40; c++) begin
            dev_irq[2] = (c < 14) && ((c % 4) < 2);
            step(1);
            check($sformatf("l3_pulse_c%0d", c), 32'(ir_map[2]), 32'((c == 2) || (c == 19)));
            if (c == 6)  check("l3_pending_set", 32'(pending[2]), 32'h1);
            if (c == 10) check("l3_lost_set", 32'(lost[2]), 32'(EXP_LOST));
            if (c == 19) check("l3_pending_clr", 32'(pending[2]), 32'h0);
        end
        lost_clr[2] = 1'b1;
        step(1);
        lost_clr[2] = 1'b0;
        check("l3_lost_clr", 32'(lost[2]), 32'h0);
        step(5);

        // Line 7 level: 60 cycles high gives pulses at 2, 19, 36, 53.
        pulse_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            dev_irq[6] = (c < 60);
            step(1);
            if (ir_map[6]) pulse_cnt++;
            check($sformatf("l7_pulse_c%0d", c), 32'(ir_map[6]),
                  32'((c == 2) || (c == 19) || (c == 36) || (c == 53)));
            check($sformatf("l7_pend_c%0d", c), 32'({lost[6], pending[6]}), 32'h0);
        end
        check("l7_pulse_count", 32'(pulse_cnt), 32'd4);

        // Line 10: mask drops pending in HOLD; edges while masked are discarded.
        for (int c = 0; c < 40; c++) begin
            dev_irq[9]  = (c < 2) || (c >= 4 && c < 6) || (c >= 10);
            irq_mask[9] = !(c >= 7 && c < 25);
            step(1);
            check($sformatf("l10_pulse_c%0d", c), 32'(ir_map[9]), 32'(c == 2));
            if (c == 6) check("l10_pending_set", 32'(pending[9]), 32'h1);
            if (c == 7) check("l10_pending_mask", 32'(pending[9]), 32'h0);
        end
        dev_irq[9] = 1'b0;
        step(20);

        // Asynchronous reset mid-HOLD with pending set on line 3.
        for (int c = 0; c < 7; c++) begin
            dev_irq[2] = (c < 2) || (c >= 4);
            step(1);
        end
        check("rstmid_pending_before", 32'(pending[2]), 32'h1);
        rst_n = 1'b0;
        #2;
        check("rstmid_pending", 32'(pending), 32'h0);
        check("rstmid_ir_map", 32'(ir_map), 32'h0);
        check("rstmid_lost", 32'(lost), 32'h0);
        dev_irq[2] = 1'b0;
        step(2);
        rst_n = 1'b1;
        pulse_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (ir_map[2]) pulse_cnt++;
        end
        check("rstmid_no_pulse", 32'(pulse_cnt), 32'h0);
        for (int c = 0; c < 4; c++) begin
            dev_irq[2] = 1'b1;
            step(1);
            check($sformatf("rstmid_new_c%0d", c), 32'(ir_map[2]), 32'(c == 2));
        end
        dev_irq[2] = 1'b0;
        step(20);

        // All lines in the same cycle, then reset while the pulse is high.
        for (int c = 0; c < 3; c++) begin
            dev_irq = '1;
            step(1);
            check($sformatf("all_map_c%0d", c), 32'(ir_map), (c == 2) ? 32'h3FFF_FFFF : 32'h0);
        end
        rst_n = 1'b0;
        #2;
        check("all_rst_ir_map", 32'(ir_map), 32'h0);
        dev_irq = '0;
        step(2);
        rst_n = 1'b1;
        step(5);
        check("all_quiet", 32'(ir_map), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
